// File: rtl/ntt_pkg.sv
// Shared constants, FSM state type and Z_q arithmetic for the NTT / inverse NTT pair.
// All helpers take canonical operands (< Q) and return canonical results.
package ntt_pkg;

    localparam int            N    = 256;
    localparam int            AW   = 8;
    localparam int            DW   = 23;
    localparam logic [DW-1:0] Q    = 23'd8380417;
    localparam logic [DW-1:0] NINV = 23'd8347681;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        BUTTERFLY,
        BLOCK_NEXT,
        STAGE_NEXT,
        OUTPUT
    } state_t;

    function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, Q}) begin
            s = s - {1'b0, Q};
        end
        return s[DW-1:0];
    endfunction

    // Wrapping 23-bit arithmetic lands on the canonical value in both branches.
    function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a >= b) ? (a - b) : (a - b + Q);
    endfunction

    // Q = 2^23 - 2^13 + 1, so 2^23 == 2^13 - 1 (mod Q): fold the high part
    // three times, leaving a value below 2Q for one final subtract.
    function automatic logic [DW-1:0] mod_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [2*DW-1:0] p;
        logic [36:0]     r1;
        logic [26:0]     r2;
        logic [23:0]     r3;
        p  = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        r1 = ({14'd0, p[45:23]} << 13) + {14'd0, p[22:0]} - {14'd0, p[45:23]};
        r2 = ({13'd0, r1[36:23]} << 13) + {4'd0, r1[22:0]} - {13'd0, r1[36:23]};
        r3 = ({20'd0, r2[26:23]} << 13) + {1'b0, r2[22:0]} - {20'd0, r2[26:23]};
        return (r3 >= {1'b0, Q}) ? (r3[DW-1:0] - Q) : r3[DW-1:0];
    endfunction

endpackage

// File: rtl/gs_bu.sv
// Combinational Gentleman-Sande butterfly: A = X+Y, B = (Y-X)*TF, all mod Q.
module gs_bu
    import ntt_pkg::*;
(
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    input  logic [DW-1:0] tf,
    output logic [DW-1:0] a,
    output logic [DW-1:0] b
);

    assign a = mod_add(x, y);
    assign b = mod_mul(mod_sub(y, x), tf);

endmodule

// File: rtl/intt.sv
// 256-point inverse NTT over Z_q: streaming load, in-place GS butterflies (len 1..128),
// then a streaming output pass scaled by N^-1.
module intt
    import ntt_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    output logic          input_ready,
    input  logic          input_valid,
    input  logic [DW-1:0] input_data,
    output logic [AW-1:0] tf_addr,
    input  logic [DW-1:0] tf_data,
    output logic          output_valid,
    output logic [DW-1:0] output_data
);

    state_t        state_q, state_d;
    logic [AW-1:0] in_cnt_q, in_cnt_d;
    logic [AW-1:0] out_cnt_q, out_cnt_d;
    logic [AW-1:0] start_q, start_d;
    logic [AW-1:0] j_q, j_d;
    logic [AW-1:0] m_q, m_d;
    logic [AW:0]   len_q, len_d;
    logic          output_valid_q, output_valid_d;
    logic [DW-1:0] output_data_q, output_data_d;

    logic [DW-1:0] mem [N];

    logic [AW-1:0] hi_idx;
    logic [AW:0]   next_start;
    logic [DW-1:0] bu_x, bu_y, bu_a, bu_b;

    assign hi_idx     = j_q + len_q[AW-1:0];
    assign next_start = {1'b0, start_q} + (len_q << 1);
    assign bu_x       = mem[j_q];
    assign bu_y       = mem[hi_idx];

    gs_bu u_bu (
        .x  (bu_x),
        .y  (bu_y),
        .tf (tf_data),
        .a  (bu_a),
        .b  (bu_b)
    );

    always_comb begin
        state_d        = state_q;
        in_cnt_d       = in_cnt_q;
        out_cnt_d      = out_cnt_q;
        start_d        = start_q;
        j_d            = j_q;
        m_d            = m_q;
        len_d          = len_q;
        output_valid_d = 1'b0;
        output_data_d  = output_data_q;
        unique case (state_q)
            IDLE: begin
                in_cnt_d  = '0;
                out_cnt_d = '0;
                start_d   = '0;
                j_d       = '0;
                m_d       = '0;
                len_d     = 9'd1;
                if (input_valid) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (input_valid) begin
                    in_cnt_d = in_cnt_q + 8'd1;
                    if (in_cnt_q == 8'd255) begin
                        state_d = BUTTERFLY;
                    end
                end
            end
            BUTTERFLY: begin
                if (({1'b0, j_q} + 9'd1) <= ({1'b0, start_q} + len_q - 9'd1)) begin
                    j_d = j_q + 8'd1;
                end else begin
                    state_d = BLOCK_NEXT;
                end
            end
            BLOCK_NEXT: begin
                // Bit 8 of the 9-bit sum flags that the stage ran off the end.
                start_d = next_start[AW-1:0];
                j_d     = next_start[AW-1:0];
                m_d     = m_q + 8'd1;
                state_d = next_start[AW] ? STAGE_NEXT : BUTTERFLY;
            end
            STAGE_NEXT: begin
                if (len_q < 9'd128) begin
                    len_d   = len_q << 1;
                    start_d = '0;
                    j_d     = '0;
                    state_d = BUTTERFLY;
                end else begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                output_data_d  = mod_mul(mem[out_cnt_q], NINV);
                output_valid_d = 1'b1;
                out_cnt_d      = out_cnt_q + 8'd1;
                if (out_cnt_q == 8'd255) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            in_cnt_q       <= '0;
            out_cnt_q      <= '0;
            start_q        <= '0;
            j_q            <= '0;
            m_q            <= '0;
            len_q          <= 9'd1;
            output_valid_q <= 1'b0;
            output_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            in_cnt_q       <= in_cnt_d;
            out_cnt_q      <= out_cnt_d;
            start_q        <= start_d;
            j_q            <= j_d;
            m_q            <= m_d;
            len_q          <= len_d;
            output_valid_q <= output_valid_d;
            output_data_q  <= output_data_d;
        end
    end

    // Coefficient storage keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (state_q == LOAD && input_valid) begin
            mem[in_cnt_q] <= input_data;
        end else if (state_q == BUTTERFLY) begin
            mem[j_q]    <= bu_a;
            mem[hi_idx] <= bu_b;
        end
    end

    assign input_ready  = (state_q == LOAD);
    assign tf_addr      = 8'd255 - m_q;
    assign output_valid = output_valid_q;
    assign output_data  = output_data_q;

endmodule

// File: tb/tb_intt.sv
// Directed + randomized bench for intt: frames are built with a forward-NTT golden model
// and the inverse result is compared against the original coefficient vector.
module tb_intt;

    localparam longint QL = 64'd8380417;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        input_ready;
    logic        input_valid = 1'b0;
    logic [22:0] input_data = '0;
    logic [7:0]  tf_addr;
    logic [22:0] tf_data;
    logic        output_valid;
    logic [22:0] output_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [22:0] zetas [256];
    longint      vec   [256];
    longint      expv  [256];
    int          trace [$];
    int          exp_trace [$];

    always #5 clk = ~clk;

    assign tf_data = zetas[tf_addr];

    intt dut (
        .clk          (clk),
        .rst          (rst),
        .input_ready  (input_ready),
        .input_valid  (input_valid),
        .input_data   (input_data),
        .tf_addr      (tf_addr),
        .tf_data      (tf_data),
        .output_valid (output_valid),
        .output_data  (output_data)
    );

    task automatic check(input string tag, input longint obs, input longint expd);
        n_cmp++;
        assert (obs === expd) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expd);
        end
    endtask

    function automatic int brv8(input int k);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) r = r | (1 << (7 - i));
        end
        return r;
    endfunction

    function automatic longint powmod(input longint b, input int e);
        longint r;
        r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % QL;
        return r;
    endfunction

    // Cooley-Tukey forward NTT (len 128 -> 1), zetas taken in increasing index order.
    task automatic fwd_ntt();
        int     k;
        longint z, t;
        k = 0;
        for (int len = 128; len > 0; len = len >> 1) begin
            for (int st = 0; st < 256; st += 2 * len) begin
                k++;
                z = longint'(zetas[k]);
                for (int j = st; j < st + len; j++) begin
                    t = (z * vec[j + len]) % QL;
                    vec[j + len] = (vec[j] + QL - t) % QL;
                    vec[j] = (vec[j] + t) % QL;
                end
            end
        end
    endtask

    // Per-cycle twiddle address expected from the first BUTTERFLY cycle until output_valid rises.
    task automatic build_exp_trace();
        int m;
        m = 0;
        exp_trace.delete();
        for (int len = 1; len <= 128; len = len * 2) begin
            for (int b = 0; b < 128 / len; b++) begin
                repeat (len + 1) exp_trace.push_back(255 - m);
                m++;
            end
            exp_trace.push_back(255 - m);
        end
        exp_trace.push_back(0);
        exp_trace.push_back(0);
    endtask

    task automatic drive_frame(input int gap_at);
        @(negedge clk);
        input_valid = 1'b1;
        input_data  = '0;
        for (int i = 0; i < 256; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < 3; g++) begin
                    @(negedge clk);
                    input_valid = 1'b0;
                    check("ready_in_gap", longint'(input_ready), 1);
                end
            end
            @(negedge clk);
            if (i == 0 || i == 255) check("ready_load", longint'(input_ready), 1);
            input_data  = 23'(vec[i]);
            input_valid = 1'b1;
        end
    endtask

    task automatic run_frame(input string name, input int gap_at, input bit chk_trace);
        int n;
        int bad;
        drive_frame(gap_at);
        n = 0;
        trace.delete();
        do begin
            @(negedge clk);
            input_valid = 1'b0;
            n++;
            trace.push_back(int'(tf_addr));
        end while (!output_valid && n < 4000);
        // 1287 compute cycles, the OUTPUT entry cycle, then the first valid beat.
        check({name, "_span"}, n, 1287 + 2);
        check({name, "_ready_low"}, longint'(input_ready), 0);
        if (chk_trace) begin
            bad = 0;
            for (int i = 0; i < exp_trace.size(); i++) begin
                if (i >= trace.size() || trace[i] != exp_trace[i]) bad++;
            end
            check({name, "_tf_trace_errs"}, bad, 0);
            check({name, "_tf_first"}, trace[0], 255);
            check({name, "_tf_len1_last"}, trace[254], 128);
            check({name, "_tf_final_bu"}, trace[1284], 1);
        end
        for (int i = 0; i < 256; i++) begin
            check({name, "_valid"}, longint'(output_valid), 1);
            check({name, $sformatf("_data[%0d]", i)}, longint'(output_data), expv[i]);
            @(negedge clk);
        end
        check({name, "_valid_drop"}, longint'(output_valid), 0);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) zetas[k] = 23'(powmod(64'd1753, brv8(k)));
        build_exp_trace();

        #12;
        check("rst_valid", longint'(output_valid), 0);
        check("rst_data", longint'(output_data), 0);
        check("rst_ready", longint'(input_ready), 0);
        check("rst_tf", longint'(tf_addr), 255);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready", longint'(input_ready), 0);

        for (int i = 0; i < 256; i++) begin
            vec[i]  = 1;
            expv[i] = (i == 0) ? 1 : 0;
        end
        run_frame("ones", -1, 1'b1);

        for (int i = 0; i < 256; i++) begin
            vec[i]  = QL - 1;
            expv[i] = (i == 0) ? QL - 1 : 0;
        end
        run_frame("qm1", -1, 1'b0);

        for (int i = 0; i < 256; i++) begin
            vec[i]  = i;
            expv[i] = i;
        end
        fwd_ntt();
        run_frame("ramp", -1, 1'b0);

        for (int i = 0; i < 256; i++) begin
            vec[i]  = longint'($urandom_range(8380416, 1));
            expv[i] = vec[i];
        end
        fwd_ntt();
        run_frame("rand_gap", 100, 1'b1);

        for (int i = 0; i < 256; i++) vec[i] = longint'($urandom_range(8380416, 0));
        drive_frame(-1);
        repeat (400) begin
            @(negedge clk);
            input_valid = 1'b0;
        end
        rst = 1'b0;
        #1;
        check("midrst_valid", longint'(output_valid), 0);
        check("midrst_data", longint'(output_data), 0);
        check("midrst_tf", longint'(tf_addr), 255);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 256; i++) begin
            vec[i]  = 1;
            expv[i] = (i == 0) ? 1 : 0;
        end
        run_frame("post_rst", -1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
